// File: rtl/vga_pkg.sv
// Shared VGA timing constants and state encodings for the video capture path.
// Pure declarations: no latency, no flow control.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CAPT  = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    SYNC   = 2'd2
  } sync_mode_t;

endpackage

// File: rtl/vga_frame_capture_sync_edge_det.sv
// Registers hs/vs/blank_n once and flags level changes against the registered copy.
// Edge pulses are combinational on the current input; no backpressure.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic hs,
  input  logic vs,
  input  logic blank_n,
  output logic hs_fall,
  output logic hs_rise,
  output logic vs_fall,
  output logic vs_rise,
  output logic blank_fall,
  output logic blank_rise
);

  logic hs_q, vs_q, blank_q;

  // Clearing to 0 keeps a reset released mid-vsync from faking a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      hs_q    <= hs;
      vs_q    <= vs;
      blank_q <= blank_n;
    end
  end

  assign hs_fall    = hs_q & ~hs;
  assign hs_rise    = ~hs_q & hs;
  assign vs_fall    = vs_q & ~vs;
  assign vs_rise    = ~vs_q & vs;
  assign blank_fall = blank_q & ~blank_n;
  assign blank_rise = ~blank_q & blank_n;

endmodule

// File: rtl/vga_frame_capture.sv
// Recovers pixel coordinates/frame timing from a VGA stream and writes captured frames to a store.
// Write port and status outputs are registered, 1 clk after the input pixel; no backpressure.
module vga_frame_capture #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 24,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hs,
  input  logic              vs,
  input  logic              blank_n,
  input  logic [DATA_W-1:0] bgr,
  input  logic              cap_req,
  input  logic              cap_cont,
  input  logic              cap_stop,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              cap_ok,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              locked,
  output logic              line_err,
  output logic              frame_err
);
  import vga_pkg::*;

  // One extra address bit so the overflow compare works even when 2**ADDR_W == frame size.
  localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [9:0]      H_LEN     = 10'(H_ACTIVE);
  localparam logic [8:0]      V_LEN     = 9'(V_ACTIVE);

  logic hs_fall, hs_rise, vs_fall, vs_rise, blank_fall, blank_rise;
  logic unused_edges;

  sync_edge_det u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .hs         (hs),
    .vs         (vs),
    .blank_n    (blank_n),
    .hs_fall    (hs_fall),
    .hs_rise    (hs_rise),
    .vs_fall    (vs_fall),
    .vs_rise    (vs_rise),
    .blank_fall (blank_fall),
    .blank_rise (blank_rise)
  );

  assign unused_edges = ^{hs_fall, hs_rise, vs_rise, blank_rise};

  logic [9:0]      x;
  logic [8:0]      y;
  logic [ADDR_W:0] addr;
  logic            frame_bad_q, cont_q, stop_seen;
  sync_mode_t      mode, mode_nxt;
  cap_state_t      cst, cst_nxt;
  logic            fb, collide, overflow, accept, qualified;
  logic            bad_line, bad_frame, any_err, stop_now;
  logic            wr_nxt, done_nxt, ok_nxt;

  always_comb begin
    fb        = vs_fall;
    collide   = fb & blank_n;
    overflow  = blank_n & ~fb & (addr == FRAME_PIX);
    accept    = blank_n & ~fb & ~overflow;
    // Lengths are measured from CHECK on (to qualify a lock) but only flagged once locked.
    qualified = (mode != SEARCH);
    bad_line  = blank_fall & qualified & (x != H_LEN);
    bad_frame = fb & qualified & (y != V_LEN);
    any_err   = bad_line | bad_frame | overflow | collide;
    stop_now  = stop_seen | cap_stop;
  end

  always_comb begin
    mode_nxt = mode;
    case (mode)
      SEARCH:  if (fb) mode_nxt = CHECK;
      CHECK:   if (fb && !frame_bad_q && !any_err) mode_nxt = SYNC;
      SYNC:    if (any_err) mode_nxt = CHECK;
      default: mode_nxt = SEARCH;
    endcase
  end

  always_comb begin
    cst_nxt  = cst;
    wr_nxt   = 1'b0;
    done_nxt = 1'b0;
    ok_nxt   = 1'b0;
    case (cst)
      IDLE:  if (cap_req && mode == SYNC) cst_nxt = ARMED;
      ARMED: if (fb) cst_nxt = CAPT;
      CAPT: begin
        wr_nxt = accept;
        if (any_err) begin
          cst_nxt  = IDLE;
          done_nxt = 1'b1;
        end else if (fb) begin
          done_nxt = 1'b1;
          ok_nxt   = 1'b1;
          if (!(cont_q && !stop_now)) cst_nxt = IDLE;
        end
      end
      default: cst_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= SEARCH;
      cst       <= IDLE;
      cont_q    <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      mode <= mode_nxt;
      cst  <= cst_nxt;
      if (cst == IDLE && cst_nxt == ARMED) begin
        cont_q    <= cap_cont;
        stop_seen <= 1'b0;
      end else if (cst != IDLE && cap_stop) begin
        stop_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      frame_bad_q <= 1'b0;
      frame_tick  <= 1'b0;
      frame_cnt   <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      pix_x       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cap_done    <= 1'b0;
      cap_ok      <= 1'b0;
    end else begin
      frame_tick  <= fb;
      cap_done    <= done_nxt;
      cap_ok      <= ok_nxt;
      wr_en       <= wr_nxt;
      frame_bad_q <= fb ? 1'b0 : (frame_bad_q | any_err);
      line_err    <= line_err | (bad_line & (mode == SYNC));
      frame_err   <= frame_err | overflow | collide | (bad_frame & (mode == SYNC));
      if (wr_nxt) begin
        wr_addr <= addr[ADDR_W-1:0];
        wr_data <= bgr;
      end
      if (fb) begin
        frame_cnt <= frame_cnt + 1'b1;
        x         <= '0;
        y         <= '0;
        addr      <= '0;
      end else begin
        // Dropped overflow pixels still count toward line length.
        if (blank_n) x <= x + 10'd1;
        if (accept) begin
          addr  <= addr + 1'b1;
          pix_x <= x;
        end
        if (blank_fall) begin
          x <= '0;
          y <= y + 9'd1;
        end
      end
    end
  end

  assign pix_y    = y;
  assign locked   = (mode == SYNC);
  assign cap_busy = (cst == ARMED) || (cst == CAPT);

endmodule
